ram_arbiter: RTL

//  Shares one single-ported RAM (synchronous, fixed read latency) between the
//  RI5CY instruction and data ports. Arbitrates per cycle, issues the winner's

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/ram_arb_resp_pipe.sv | 30 +++
 rtl/ram_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM arbiter: response owner tags and the latency ceiling.
package ram_arb_pkg;

   typedef enum logic {OWNER_INSTR = 1'b0, OWNER_DATA = 1'b1} owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
   } resp_tag_t;

   localparam int unsigned RAM_ARB_MAX_LATENCY = 4;

   function automatic bit latency_in_range(int unsigned lat);
      return (lat >= 1) && (lat <= RAM_ARB_MAX_LATENCY);
   endfunction

endpackage

// File: rtl/ram_arb_resp_pipe.sv
// Owner pipe: a DEPTH-stage shift register of response tags. The last stage
// tells the top which requester owns the read data arriving this cycle.
module ram_arb_resp_pipe
   import ram_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic      clk,
   input  logic      rst_n,
   input  resp_tag_t tag_in,
   output resp_tag_t tag_out
);

   resp_tag_t [DEPTH-1:0] stages;

   // Reset empties every stage so nothing granted before reset is answered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stages <= '0;
      end else begin
         stages[0] <= tag_in;
         for (int i = 1; i < int'(DEPTH); i++) begin
            stages[i] <= stages[i-1];
         end
      end
   end

   assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/ram_arbiter.sv
// Shares one fixed-latency single-port RAM between the instruction and data
// ports. Define RAM_ARBITER_ROUND_ROBIN_EN for alternating grants under contention.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 22,
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  instr_req_i,
   input  logic [ADDR_WIDTH-1:0] instr_addr_i,
   output logic                  instr_gnt_o,
   output logic                  instr_rvalid_o,
   output logic [31:0]           instr_rdata_o,
   input  logic                  data_req_i,
   input  logic [ADDR_WIDTH-1:0] data_addr_i,
   input  logic                  data_we_i,
   input  logic [3:0]            data_be_i,
   input  logic [31:0]           data_wdata_i,
   output logic                  data_gnt_o,
   output logic                  data_rvalid_o,
   output logic [31:0]           data_rdata_o,
   output logic                  mem_req_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic                  mem_we_o,
   output logic [3:0]            mem_be_o,
   output logic [31:0]           mem_wdata_o,
   input  logic [31:0]           mem_rdata_i
);

   if (!latency_in_range(MEM_LATENCY)) begin : g_bad_latency
      $error("ram_arbiter: MEM_LATENCY must be within 1..%0d", RAM_ARB_MAX_LATENCY);
   end

   localparam int unsigned PIPE_DEPTH = (MEM_LATENCY < 1) ? 1 : MEM_LATENCY;

   owner_e    last_grant;
   logic      pick_data;
   resp_tag_t tag_in;
   resp_tag_t tag_out;

   // Arbitration: combinational, same cycle as the request, no request state.
   always_comb begin
      pick_data   = 1'b0;
      instr_gnt_o = 1'b0;
      data_gnt_o  = 1'b0;
      if (rst_n) begin
         if (instr_req_i && data_req_i) begin
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
            pick_data = (last_grant == OWNER_INSTR);
`else
            pick_data = 1'b1;
`endif
         end else begin
            pick_data = data_req_i;
         end
         data_gnt_o  = data_req_i & pick_data;
         instr_gnt_o = instr_req_i & ~pick_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= OWNER_INSTR;
      end else if (instr_gnt_o || data_gnt_o) begin
         last_grant <= data_gnt_o ? OWNER_DATA : OWNER_INSTR;
      end
   end

   // Issue mux: instruction fetches are always full-word reads.
   always_comb begin
      mem_req_o   = instr_gnt_o | data_gnt_o;
      mem_addr_o  = '0;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'b0000;
      mem_wdata_o = 32'h0;
      if (data_gnt_o) begin
         mem_addr_o  = data_addr_i;
         mem_we_o    = data_we_i;
         mem_be_o    = data_be_i;
         mem_wdata_o = data_wdata_i;
      end else if (instr_gnt_o) begin
         mem_addr_o  = instr_addr_i;
         mem_be_o    = 4'b1111;
      end
   end

   always_comb begin
      tag_in       = '0;
      tag_in.valid = mem_req_o;
      tag_in.owner = data_gnt_o ? OWNER_DATA : OWNER_INSTR;
   end

   ram_arb_resp_pipe #(
      .DEPTH (PIPE_DEPTH)
   ) u_resp_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   // Response demux: the RAM word is only visible to the port that owns it.
   always_comb begin
      instr_rvalid_o = tag_out.valid && (tag_out.owner == OWNER_INSTR);
      data_rvalid_o  = tag_out.valid && (tag_out.owner == OWNER_DATA);
      instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'h0;
      data_rdata_o   = data_rvalid_o  ? mem_rdata_i : 32'h0;
   end

   always_comb begin
      assert (!(instr_gnt_o && data_gnt_o));
   end

   a_last_data : assert property (@(posedge clk) disable iff (!rst_n)
      data_gnt_o |=> (last_grant == OWNER_DATA));
   a_last_instr : assert property (@(posedge clk) disable iff (!rst_n)
      instr_gnt_o |=> (last_grant == OWNER_INSTR));

endmodule
